// File: rtl/flag_bank_pkg.sv
// common_p: shared flag mode encoding for the flag bank
package common_p;

    typedef enum logic [1:0] {
        FLAG_LEVEL  = 2'b00,
        FLAG_PULSE  = 2'b01,
        FLAG_STICKY = 2'b10,
        FLAG_RSVD   = 2'b11
    } flag_mode_t;

endpackage

// File: rtl/flag_channel.sv
// flag_channel: one flag with clear>set>toggle priority, PULSE auto-clear counter and rise/fall strobes
module flag_channel
    import common_p::*;
#(
    parameter int PULSE_W = 4
) (
    input  logic               clk,
    input  logic               sync_rst_n,
    input  logic               clk_en,
    input  logic               clear_i,
    input  logic               set_i,
    input  logic               toggle_i,
    input  flag_mode_t         mode_i,
    input  logic [PULSE_W-1:0] pulse_len_i,
    output logic               state_o,
    output logic               rise_o,
    output logic               fall_o
);

    logic               r_state;
    logic               r_rise;
    logic               r_fall;
    logic [PULSE_W-1:0] r_cnt;
    logic               w_state_nxt;
    logic [PULSE_W-1:0] w_cnt_nxt;
    logic [PULSE_W-1:0] w_len;
    logic               w_load;

    // A zero pulse length still gives a one-cycle pulse.
    assign w_len  = (pulse_len_i == '0) ? PULSE_W'(1) : pulse_len_i;
    assign w_load = set_i | (toggle_i & ~r_state);

    // Next state/counter; the counter only lives in PULSE mode, so leaving PULSE zeroes it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (clear_i)
            w_state_nxt = 1'b0;
        else if (mode_i == FLAG_PULSE) begin
            if (w_load) begin
                w_state_nxt = 1'b1;
                w_cnt_nxt   = w_len;
            end else if (toggle_i)
                w_state_nxt = 1'b0;
            else if (r_state && r_cnt > PULSE_W'(1))
                w_cnt_nxt = r_cnt - PULSE_W'(1);
            else
                w_state_nxt = 1'b0;
        end else if (set_i)
            w_state_nxt = 1'b1;
        else if (toggle_i && mode_i != FLAG_STICKY)
            w_state_nxt = ~r_state;
    end

    // State, counter and edge strobes; strobes drop on any disabled cycle.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= ~r_state & w_state_nxt;
            r_fall  <= r_state & ~w_state_nxt;
        end else begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end
    end

    assign state_o = r_state;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

endmodule

// File: rtl/flag_bank.sv
// flag_bank: WIDTH independent flag channels with a bank-wide any-flag summary
module flag_bank
    import common_p::*;
#(
    parameter int WIDTH   = 8,
    parameter int PULSE_W = 4
) (
    input  logic                 clk,
    input  logic                 sync_rst_n,
    input  logic                 clk_en,
    input  logic [WIDTH-1:0]     clear_i,
    input  logic [WIDTH-1:0]     set_i,
    input  logic [WIDTH-1:0]     toggle_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [PULSE_W-1:0]   pulse_len_i,
    output logic [WIDTH-1:0]     state_o,
    output logic [WIDTH-1:0]     rise_o,
    output logic [WIDTH-1:0]     fall_o,
    output logic                 any_o
);

    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_ch
            flag_channel #(.PULSE_W(PULSE_W)) u_ch (
                .clk        (clk),
                .sync_rst_n (sync_rst_n),
                .clk_en     (clk_en),
                .clear_i    (clear_i[k]),
                .set_i      (set_i[k]),
                .toggle_i   (toggle_i[k]),
                .mode_i     (flag_mode_t'(mode_i[2*k +: 2])),
                .pulse_len_i(pulse_len_i),
                .state_o    (state_o[k]),
                .rise_o     (rise_o[k]),
                .fall_o     (fall_o[k])
            );
        end
    endgenerate

    assign any_o = |state_o;

endmodule
